rfi_moment_acc: RTL and testbench

RFI_MOMENT_ACC -- requirements
Module: rfi_moment_acc

---
 rtl/rfi_moment_acc.sv | 193 +++++++++++++++++++
 tb/tb_rfi_moment_acc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rfi_moment_acc.sv
// rfi_moment_acc
//
// Accumulates, per channel word and per lane, the sum and the sum of squares
// of ACC_LEN consecutive spectra. These are the first and second moments used
// for RFI detection. Each spectrum is VECTOR_LEN words of PARALLEL signed lanes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         PARALLEL signed samples, lane 0 in the LSBs (binary point DIN_POINT)
//   din_valid   din is qualified this cycle
//   sync_in     one-cycle pulse; the next valid word is word 0 of spectrum 0
//   sum_out     PARALLEL signed sums, SUM_WIDTH bits each (binary point DIN_POINT)
//   sumsq_out   PARALLEL unsigned sums of squares, SQ_WIDTH bits each (point 2*DIN_POINT)
//   dout_valid  sum_out / sumsq_out / addr_out carry a new result
//   sync_out    high with dout_valid for channel word 0
//   addr_out    channel word index of the current result
//
// Handshake: din is consumed on every cycle where din_valid is high and the
// block is accumulating; there is no backpressure. dout_valid is a single-cycle
// strobe that fires exactly 3 cycles after the input word that completes a
// channel. Outputs hold their value between strobes.
//
// Pipeline: stage 1 registers the sample, its square and the RAM read data.
// Stage 2 adds. Stage 3 writes the RAM back, or loads the output registers on
// the last spectrum. A channel word is revisited only after VECTOR_LEN >= 4
// words, so a read never sees a stale value.
module rfi_moment_acc #(
  parameter int DIN_WIDTH  = 9,
  parameter int DIN_POINT  = 8,
  parameter int PARALLEL   = 4,
  parameter int VECTOR_LEN = 64,
  parameter int ACC_LEN    = 1024,
  localparam int AW        = $clog2(VECTOR_LEN),
  localparam int CW        = $clog2(ACC_LEN),
  localparam int SUM_WIDTH = DIN_WIDTH + CW,
  localparam int SQ_WIDTH  = 2*DIN_WIDTH + CW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIN_WIDTH*PARALLEL-1:0] din,
  input  logic                          din_valid,
  input  logic                          sync_in,
  output logic [SUM_WIDTH*PARALLEL-1:0] sum_out,
  output logic [SQ_WIDTH*PARALLEL-1:0]  sumsq_out,
  output logic                          dout_valid,
  output logic                          sync_out,
  output logic [AW-1:0]                 addr_out
);

  localparam int SW = SUM_WIDTH*PARALLEL;
  localparam int QW = SQ_WIDTH*PARALLEL;

  if (DIN_POINT > DIN_WIDTH || VECTOR_LEN < 4 || ACC_LEN < 2 ||
      (VECTOR_LEN & (VECTOR_LEN-1)) != 0 || (ACC_LEN & (ACC_LEN-1)) != 0) begin : g_bad_params
    $error("rfi_moment_acc: illegal parameter combination");
  end

  typedef enum logic {WAIT_SYNC = 1'b0, ACC = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] w_q, w_d;
  logic [CW-1:0] s_q, s_d;
  logic          accept;

  // Stage 1
  logic          v1_q, first1_q, last1_q;
  logic [AW-1:0] w1_q;
  logic [SW-1:0] x1_sum_q, rd_sum_q;
  logic [QW-1:0] x1_sq_q, rd_sq_q;
  // Stage 2
  logic          v2_q, last2_q;
  logic [AW-1:0] w2_q;
  logic [SW-1:0] acc_sum_d, acc_sum_q;
  logic [QW-1:0] acc_sq_d, acc_sq_q;
  // Stage 3 / outputs
  logic          dout_valid_q, sync_out_q;
  logic [AW-1:0] addr_q;
  logic [SW-1:0] sum_q;
  logic [QW-1:0] sumsq_q;

  logic [SW-1:0] x_sum;
  logic [QW-1:0] x_sq;

  logic [SW-1:0] sum_ram [VECTOR_LEN];
  logic [QW-1:0] sq_ram  [VECTOR_LEN];

  // Control: sync_in always wins, so a word arriving with it is dropped.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    accept  = 1'b0;
    if (sync_in) begin
      state_d = ACC;
      w_d     = '0;
      s_d     = '0;
    end else if (state_q == ACC && din_valid) begin
      accept = 1'b1;
      w_d    = w_q + AW'(1);
      if (w_q == AW'(VECTOR_LEN-1)) begin
        s_d = s_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SYNC;
      w_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
    end
  end

  // Per-lane extension and squaring; also the per-lane stage-2 add.
  // Restarting from zero on the first spectrum removes any clearing pass.
  for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
    logic signed [DIN_WIDTH-1:0]   smp;
    logic signed [2*DIN_WIDTH-1:0] prod;
    assign smp  = din[l*DIN_WIDTH +: DIN_WIDTH];
    assign prod = smp * smp;
    assign x_sum[l*SUM_WIDTH +: SUM_WIDTH] = {{CW{smp[DIN_WIDTH-1]}}, smp};
    assign x_sq[l*SQ_WIDTH +: SQ_WIDTH]    = {{CW{1'b0}}, prod};

    assign acc_sum_d[l*SUM_WIDTH +: SUM_WIDTH] =
      (first1_q ? '0 : rd_sum_q[l*SUM_WIDTH +: SUM_WIDTH]) + x1_sum_q[l*SUM_WIDTH +: SUM_WIDTH];
    assign acc_sq_d[l*SQ_WIDTH +: SQ_WIDTH] =
      (first1_q ? '0 : rd_sq_q[l*SQ_WIDTH +: SQ_WIDTH]) + x1_sq_q[l*SQ_WIDTH +: SQ_WIDTH];
  end

  // Accumulator RAMs: synchronous read at stage 1, write-back at stage 3.
  always_ff @(posedge clk) begin
    if (v2_q && !last2_q) begin
      sum_ram[w2_q] <= acc_sum_q;
      sq_ram[w2_q]  <= acc_sq_q;
    end
    rd_sum_q <= sum_ram[w_q];
    rd_sq_q  <= sq_ram[w_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      first1_q     <= 1'b0;
      last1_q      <= 1'b0;
      w1_q         <= '0;
      x1_sum_q     <= '0;
      x1_sq_q      <= '0;
      v2_q         <= 1'b0;
      last2_q      <= 1'b0;
      w2_q         <= '0;
      acc_sum_q    <= '0;
      acc_sq_q     <= '0;
      dout_valid_q <= 1'b0;
      sync_out_q   <= 1'b0;
      addr_q       <= '0;
      sum_q        <= '0;
      sumsq_q      <= '0;
    end else begin
      v1_q     <= accept;
      first1_q <= (s_q == '0);
      last1_q  <= (s_q == CW'(ACC_LEN-1));
      w1_q     <= w_q;
      x1_sum_q <= x_sum;
      x1_sq_q  <= x_sq;

      v2_q      <= v1_q;
      last2_q   <= last1_q;
      w2_q      <= w1_q;
      acc_sum_q <= acc_sum_d;
      acc_sq_q  <= acc_sq_d;

      dout_valid_q <= v2_q && last2_q;
      sync_out_q   <= v2_q && last2_q && (w2_q == '0);
      if (v2_q && last2_q) begin
        addr_q  <= w2_q;
        sum_q   <= acc_sum_q;
        sumsq_q <= acc_sq_q;
      end
    end
  end

  assign sum_out    = sum_q;
  assign sumsq_out  = sumsq_q;
  assign dout_valid = dout_valid_q;
  assign sync_out   = sync_out_q;
  assign addr_out   = addr_q;

endmodule

// File: tb/tb_rfi_moment_acc.sv
// Testbench for rfi_moment_acc with PARALLEL=2, VECTOR_LEN=4, ACC_LEN=4.
module tb_rfi_moment_acc;

  localparam int DW  = 9;
  localparam int P   = 2;
  localparam int VL  = 4;
  localparam int AL  = 4;
  localparam int SWL = 11;            // SUM_WIDTH per lane
  localparam int QWL = 20;            // SQ_WIDTH per lane
  localparam int EW  = 2*SWL + 2*QWL + 2 + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DW*P-1:0]     din;
  logic                din_valid;
  logic                sync_in;
  logic [SWL*P-1:0]    sum_out;
  logic [QWL*P-1:0]    sumsq_out;
  logic                dout_valid;
  logic                sync_out;
  logic [1:0]          addr_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  rfi_moment_acc #(
    .DIN_WIDTH(DW), .DIN_POINT(8), .PARALLEL(P), .VECTOR_LEN(VL), .ACC_LEN(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync_in(sync_in),
    .sum_out(sum_out), .sumsq_out(sumsq_out), .dout_valid(dout_valid),
    .sync_out(sync_out), .addr_out(addr_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [SWL-1:0] s0, input logic [SWL-1:0] s1,
                                       input logic [QWL-1:0] q0, input logic [QWL-1:0] q1,
                                       input logic [1:0] a);
    return {s1, s0, q1, q0, a, (a == 2'd0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
      sync_in   = 1'b0;
    end
  endtask

  task automatic pulse_sync();
    @(posedge clk); #1;
    din_valid = 1'b0;
    sync_in   = 1'b1;
  endtask

  // sync_in together with a valid word: that word must be dropped.
  task automatic sync_with_word(input logic [DW-1:0] v);
    @(posedge clk); #1;
    din       = {v, v};
    din_valid = 1'b1;
    sync_in   = 1'b1;
  endtask

  task automatic send_word(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                           input bit has_exp, input logic [EW-1:0] e);
    @(posedge clk); #1;
    din       = {l1, l0};
    din_valid = 1'b1;
    sync_in   = 1'b0;
    if (has_exp) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 3);
    end
  endtask

  // n words of a constant value on both lanes; results expected on the last spectrum.
  task automatic run_const(input int n, input logic [DW-1:0] v, input bit gapped,
                           input logic [SWL-1:0] es, input logic [QWL-1:0] eq);
    for (int i = 0; i < n; i++) begin
      logic [1:0] w;
      int         s;
      w = 2'(i % VL);
      s = (i / VL) % AL;
      if (gapped && i > 0) idle(1);
      send_word(v, v, (s == AL-1), pk(es, es, eq, eq, w));
    end
  endtask

  // lane0 = w*0x010, lane1 = -lane0.
  // Hand results: sum0 = w*0x40, sum1 = -w*0x40, sumsq = w*w*0x400 on both lanes.
  task automatic run_lanes(input int n);
    logic [SWL-1:0] es0 [VL];
    logic [SWL-1:0] es1 [VL];
    logic [QWL-1:0] eq  [VL];
    logic [DW-1:0]  l0  [VL];
    logic [DW-1:0]  l1  [VL];
    l0[0] = 9'h000; l0[1] = 9'h010; l0[2] = 9'h020; l0[3] = 9'h030;
    l1[0] = 9'h000; l1[1] = 9'h1F0; l1[2] = 9'h1E0; l1[3] = 9'h1D0;
    es0[0] = 11'h000; es0[1] = 11'h040; es0[2] = 11'h080; es0[3] = 11'h0C0;
    es1[0] = 11'h000; es1[1] = 11'h7C0; es1[2] = 11'h780; es1[3] = 11'h740;
    eq[0]  = 20'h00000; eq[1] = 20'h00400; eq[2] = 20'h01000; eq[3] = 20'h02400;
    for (int i = 0; i < n; i++) begin
      int w;
      int s;
      w = i % VL;
      s = (i / VL) % AL;
      send_word(l0[w], l1[w], (s == AL-1), pk(es0[w], es1[w], eq[w], eq[w], 2'(w)));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    check({tag, "_sync_out"},   64'(sync_out),   64'd0);
    check({tag, "_sum_out"},    64'(sum_out),    64'd0);
    check({tag, "_sumsq_out"},  64'(sumsq_out),  64'd0);
    check({tag, "_addr_out"},   64'(addr_out),   64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dout: dout_valid=1 addr=%0d with nothing expected (cycle %0d)",
                 addr_out, cyc);
      end else begin
        logic [EW-1:0] e;
        int            ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("latency",  64'(cyc),       64'(ec));
        check("sum",      64'(sum_out),   64'(e[EW-1 -: 2*SWL]));
        check("sumsq",    64'(sumsq_out), 64'(e[2*QWL+2 : 3]));
        check("addr",     64'(addr_out),  64'(e[2:1]));
        check("sync_out", 64'(sync_out),  64'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_zero_outputs("reset");

    // Constant 0.25: sum 1.0, sumsq 4*0x1000
    pulse_sync();
    run_const(16, 9'h040, 1'b0, 11'h100, 20'h04000);
    idle(6);

    // Negative extreme -1.0: sum -4.0, sumsq 4*0x10000
    pulse_sync();
    run_const(16, 9'h100, 1'b0, 11'h400, 20'h40000);
    idle(6);

    // Gapped input, same results as the continuous run
    pulse_sync();
    run_const(16, 9'h040, 1'b1, 11'h100, 20'h04000);
    idle(6);

    // Re-sync after 7 words: the partial run is discarded
    pulse_sync();
    run_const(7, 9'h0A0, 1'b0, 11'h000, 20'h00000);
    pulse_sync();
    run_const(16, 9'h040, 1'b0, 11'h100, 20'h04000);
    idle(6);

    // sync_in together with a valid word: the concurrent word is dropped
    sync_with_word(9'h0FF);
    run_const(16, 9'h040, 1'b0, 11'h100, 20'h04000);
    idle(6);

    // Lane independence across two full accumulations (s wraps back to 0)
    pulse_sync();
    run_lanes(32);
    idle(6);

    // Reset in the middle of a run
    pulse_sync();
    run_const(10, 9'h040, 1'b0, 11'h100, 20'h04000);
    @(posedge clk); #1;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_zero_outputs("midrun_reset");
    // Valid words without a sync must produce nothing
    for (int i = 0; i < 20; i++) send_word(9'h040, 9'h040, 1'b0, '0);
    idle(6);
    check_zero_outputs("no_sync");
    // Normal operation afterwards, -0.25: sum -1.0, sumsq 0x4000
    pulse_sync();
    run_const(16, 9'h1C0, 1'b0, 11'h700, 20'h04000);
    idle(1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
